// File: rtl/ddr_cmd_arbiter.sv
// ddr_cmd_arbiter: two-port round-robin command arbiter that launches
// one read or write burst at a time on the DDR engines.
module ddr_cmd_arbiter #(
  parameter int ADDR_WIDTH      = 29,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req0_valid,
  input  logic                       req0_rw,
  input  logic [ADDR_WIDTH-1:0]      req0_addr,
  input  logic [BURST_LEN_WIDTH-1:0] req0_len,
  output logic                       req0_ack,
  output logic                       req0_done,
  output logic                       req0_err,
  input  logic                       req1_valid,
  input  logic                       req1_rw,
  input  logic [ADDR_WIDTH-1:0]      req1_addr,
  input  logic [BURST_LEN_WIDTH-1:0] req1_len,
  output logic                       req1_ack,
  output logic                       req1_done,
  output logic                       req1_err,
  input  logic                       rd_fifo_almost_full,
  output logic                       rd_start,
  output logic [ADDR_WIDTH-1:0]      rd_start_addr,
  output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
  input  logic                       rd_ready,
  input  logic                       rd_done,
  output logic                       wr_start,
  output logic [ADDR_WIDTH-1:0]      wr_start_addr,
  output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
  input  logic                       wr_ready,
  input  logic                       wr_done,
  output logic                       busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t                     state_q, state_d;
  logic                       last_q, last_d;
  logic                       own_q, own_d;
  logic                       rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       ack0_q, ack0_d;
  logic                       ack1_q, ack1_d;
  logic                       done0_q, done0_d;
  logic                       done1_q, done1_d;
  logic                       err0_q, err0_d;
  logic                       err1_q, err1_d;
  logic                       rd_start_q, rd_start_d;
  logic                       wr_start_q, wr_start_d;
  logic                       busy_q, busy_d;

  logic prio_last;
  logic grant_any;
  logic grant1;
  logic launch_ok;
  logic done_hit;
  logic timed_out;

  // DONE arbitrates with the owner already counted as last served
  always_comb begin
    prio_last = (state_q == DONE) ? own_q : last_q;
    grant_any = req0_valid | req1_valid;
    grant1    = req1_valid & (~req0_valid | ~prio_last);
    launch_ok = rw_q ? wr_ready
                     : (rd_ready & ~rd_fifo_almost_full);
    done_hit  = rw_q ? wr_done : rd_done;
    timed_out = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    own_d      = own_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rd_start_d = 1'b0;
    wr_start_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          last_d = own_q;
          cnt_d  = '0;
        end
        if (grant_any) begin
          own_d   = grant1;
          rw_d    = grant1 ? req1_rw : req0_rw;
          addr_d  = grant1 ? req1_addr : req0_addr;
          len_d   = grant1 ? req1_len : req0_len;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (launch_ok) begin
          rd_start_d = ~rw_q;
          wr_start_d = rw_q;
          cnt_d      = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (done_hit || timed_out) begin
          done0_d = ~own_q;
          done1_d = own_q;
          err0_d  = ~done_hit & ~own_q;
          err1_d  = ~done_hit & own_q;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      own_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      own_q      <= own_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rd_start_q <= rd_start_d;
      wr_start_q <= wr_start_d;
      busy_q     <= busy_d;
    end
  end

  assign req0_ack      = ack0_q;
  assign req0_done     = done0_q;
  assign req0_err      = err0_q;
  assign req1_ack      = ack1_q;
  assign req1_done     = done1_q;
  assign req1_err      = err1_q;
  assign rd_start      = rd_start_q;
  assign rd_start_addr = addr_q;
  assign rd_burst_len  = len_q;
  assign wr_start      = wr_start_q;
  assign wr_start_addr = addr_q;
  assign wr_burst_len  = len_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// tb_ddr_cmd_arbiter: directed plus randomized command sequences
// checked against a rule-level model of the arbiter.
module tb_ddr_cmd_arbiter;

  localparam int AW = 29;
  localparam int LW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req0_valid = 0, req0_rw = 0;
  logic [AW-1:0] req0_addr = '0;
  logic [LW-1:0] req0_len = '0;
  logic          req0_ack, req0_done, req0_err;
  logic          req1_valid = 0, req1_rw = 0;
  logic [AW-1:0] req1_addr = '0;
  logic [LW-1:0] req1_len = '0;
  logic          req1_ack, req1_done, req1_err;
  logic          rd_fifo_almost_full = 0;
  logic          rd_start, wr_start;
  logic [AW-1:0] rd_start_addr, wr_start_addr;
  logic [LW-1:0] rd_burst_len, wr_burst_len;
  logic          rd_ready = 1, rd_done = 0;
  logic          wr_ready = 1, wr_done = 0;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int last_srv = 1;
  int nstart = 0;

  always #5 clk = ~clk;

  ddr_cmd_arbiter #(
    .ADDR_WIDTH(AW),
    .BURST_LEN_WIDTH(LW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_rw(req0_rw),
    .req0_addr(req0_addr), .req0_len(req0_len),
    .req0_ack(req0_ack), .req0_done(req0_done),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_rw(req1_rw),
    .req1_addr(req1_addr), .req1_len(req1_len),
    .req1_ack(req1_ack), .req1_done(req1_done),
    .req1_err(req1_err),
    .rd_fifo_almost_full(rd_fifo_almost_full),
    .rd_start(rd_start), .rd_start_addr(rd_start_addr),
    .rd_burst_len(rd_burst_len), .rd_ready(rd_ready),
    .rd_done(rd_done),
    .wr_start(wr_start), .wr_start_addr(wr_start_addr),
    .wr_burst_len(wr_burst_len), .wr_ready(wr_ready),
    .wr_done(wr_done),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      chk("dual_start", rd_start & wr_start, 0);
      chk("err0_alone", req0_err & ~req0_done, 0);
      chk("err1_alone", req1_err & ~req1_done, 0);
      nstart += int'(rd_start) + int'(wr_start);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // round-robin rule: a lone requester wins, else the one not last served
  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return (last_srv == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  function automatic logic ack_of(input int p);
    return (p != 0) ? req1_ack : req0_ack;
  endfunction

  function automatic logic done_of(input int p);
    return (p != 0) ? req1_done : req0_done;
  endfunction

  function automatic logic err_of(input int p);
    return (p != 0) ? req1_err : req0_err;
  endfunction

  task automatic drive(input int p, input logic rw,
                       input logic [AW-1:0] a, input logic [LW-1:0] l);
    if (p == 0) begin
      req0_valid = 1; req0_rw = rw; req0_addr = a; req0_len = l;
    end else begin
      req1_valid = 1; req1_rw = rw; req1_addr = a; req1_len = l;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack0"}, req0_ack, 0);
    chk({tag, "_ack1"}, req1_ack, 0);
    chk({tag, "_done0"}, req0_done, 0);
    chk({tag, "_done1"}, req1_done, 0);
    chk({tag, "_err0"}, req0_err, 0);
    chk({tag, "_err1"}, req1_err, 0);
    chk({tag, "_rdst"}, rd_start, 0);
    chk({tag, "_wrst"}, wr_start, 0);
    chk({tag, "_rdaddr"}, rd_start_addr, 0);
    chk({tag, "_wraddr"}, wr_start_addr, 0);
    chk({tag, "_rdlen"}, rd_burst_len, 0);
    chk({tag, "_wrlen"}, wr_burst_len, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // single-requester command with full cycle-level expectations
  task automatic run_cmd(input int p, input logic rw,
                         input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input int stall, input bit afs, input int k,
                         input bit spur, input bit to, input string tag);
    bit thr;
    thr = afs && !rw;
    rd_fifo_almost_full = 0;
    if (thr) rd_fifo_almost_full = 1;
    else if (stall > 0) begin
      if (rw) wr_ready = 0;
      else rd_ready = 0;
    end
    if (rw) rd_fifo_almost_full = ($urandom_range(0, 1) == 1);
    drive(p, rw, a, l);
    tick();
    chk({tag, "_ack"}, ack_of(p), 1);
    chk({tag, "_ack_other"}, ack_of(1 - p), 0);
    chk({tag, "_busy_ack"}, busy, 1);
    chk({tag, "_nostart_ack"}, rd_start | wr_start, 0);
    drop(p);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_held"}, rd_start | wr_start, 0);
      chk({tag, "_busy_held"}, busy, 1);
    end
    rd_ready = 1;
    wr_ready = 1;
    if (thr) rd_fifo_almost_full = 0;
    tick();
    chk({tag, "_rdst"}, rd_start, !rw);
    chk({tag, "_wrst"}, wr_start, rw);
    chk({tag, "_addr"}, rw ? wr_start_addr : rd_start_addr, a);
    chk({tag, "_len"}, rw ? wr_burst_len : rd_burst_len, l);
    if (!rw) rd_fifo_almost_full = ($urandom_range(0, 1) == 1);
    if (to) begin
      for (int i = 0; i < TO - 1; i++) begin
        tick();
        chk({tag, "_to_wait"}, done_of(p), 0);
        chk({tag, "_to_onestart"}, rd_start | wr_start, 0);
      end
      tick();
      chk({tag, "_to_done"}, done_of(p), 1);
      chk({tag, "_to_err"}, err_of(p), 1);
    end else begin
      for (int i = 0; i < k; i++) begin
        if (spur) begin
          if (rw) rd_done = 1;
          else wr_done = 1;
        end
        tick();
        rd_done = 0;
        wr_done = 0;
        chk({tag, "_wait"}, done_of(p), 0);
        chk({tag, "_onestart"}, rd_start | wr_start, 0);
      end
      if (rw) wr_done = 1;
      else rd_done = 1;
      tick();
      rd_done = 0;
      wr_done = 0;
      chk({tag, "_done"}, done_of(p), 1);
      chk({tag, "_noerr"}, err_of(p), 0);
    end
    chk({tag, "_done_other"}, done_of(1 - p), 0);
    chk({tag, "_addr_hold"}, rw ? wr_start_addr : rd_start_addr, a);
    last_srv = p;
    rd_fifo_almost_full = 0;
    tick();
    chk({tag, "_done_pulse"}, done_of(p), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // waits for the next grant with the engines always ready
  task automatic serve(input int expp, input logic erw,
                       input logic [AW-1:0] ea, input logic [LW-1:0] el,
                       input int k, input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (!(req0_ack | req1_ack) && n < 40);
    chk({tag, "_ack_seen"}, req0_ack | req1_ack, 1);
    chk({tag, "_grant"}, req1_ack, expp[0]);
    chk({tag, "_one_ack"}, req0_ack & req1_ack, 0);
    n = 0;
    do begin tick(); n++; end
    while (!(rd_start | wr_start) && n < 40);
    chk({tag, "_start_seen"}, rd_start | wr_start, 1);
    chk({tag, "_kind"}, wr_start, erw);
    chk({tag, "_addr"}, erw ? wr_start_addr : rd_start_addr, ea);
    chk({tag, "_len"}, erw ? wr_burst_len : rd_burst_len, el);
    repeat (k) tick();
    if (erw) wr_done = 1;
    else rd_done = 1;
    tick();
    rd_done = 0;
    wr_done = 0;
    chk({tag, "_done"}, done_of(expp), 1);
    chk({tag, "_err"}, err_of(expp), 0);
    last_srv = expp;
  endtask

  task automatic do_reset(input string tag);
    rstn = 0;
    #2;
    check_zero(tag);
    tick();
    rstn = 1;
    last_srv = 1;
    tick();
  endtask

  initial begin
    logic [AW-1:0] a0, a1, ra;
    logic [LW-1:0] l0, l1, rl;
    int ns, exp_p, p;
    bit v0, v1, rrw, to;

    repeat (2) tick();
    check_zero("reset");
    rstn = 1;
    last_srv = 1;
    tick();

    run_cmd(0, 0, 29'h100, 8'd15, 0, 0, 3, 0, 0, "basic_rd");
    run_cmd(1, 0, 29'h2345, 8'd7, 20, 1, 2, 0, 0, "afull");
    run_cmd(1, 1, 29'h777, 8'd3, 0, 0, 0, 0, 1, "timeout");
    run_cmd(0, 0, 29'h40, 8'd1, 0, 0, 1, 0, 0, "after_to");
    run_cmd(0, 1, 29'h1abc, 8'd9, 0, 0, 5, 1, 0, "spur");
    run_cmd(1, 1, 29'h55, 8'd2, 0, 0, TO - 1, 0, 0, "edge_done");

    do_reset("rst2");
    a0 = 29'h1000; l0 = 8'd4;
    a1 = 29'h2000; l1 = 8'd8;
    drive(0, 0, a0, l0);
    drive(1, 1, a1, l1);
    v0 = 1; v1 = 1;
    ns = nstart;
    for (int g = 0; g < 4; g++) begin
      exp_p = pick(v0, v1);
      serve(exp_p, exp_p[0], exp_p ? a1 : a0, exp_p ? l1 : l0,
            int'($urandom_range(0, 5)), "rr");
      if (g == 2) begin drop(0); v0 = 0; end
      if (g == 3) begin drop(1); v1 = 0; end
    end
    tick();
    chk("rr_idle", busy, 0);
    chk("rr_starts", nstart - ns, 4);

    drive(1, 1, 29'h3333, 8'd6);
    tick();
    chk("rw_ack", req1_ack, 1);
    drop(1);
    tick();
    chk("rw_start", wr_start, 1);
    tick();
    do_reset("rst_wait");
    wr_done = 1;
    tick();
    wr_done = 0;
    repeat (3) begin
      chk("rw_nodone0", req0_done, 0);
      chk("rw_nodone1", req1_done, 0);
      chk("rw_idle", busy, 0);
      tick();
    end
    drive(0, 0, 29'h44, 8'd5);
    drive(1, 1, 29'h88, 8'd6);
    serve(pick(1, 1), 0, 29'h44, 8'd5, 2, "rw_c0");
    drop(0);
    serve(pick(0, 1), 1, 29'h88, 8'd6, 1, "rw_c1");
    drop(1);
    tick();
    chk("rw_end_idle", busy, 0);

    for (int i = 0; i < 24; i++) begin
      p = int'($urandom_range(0, 1));
      rrw = ($urandom_range(0, 1) == 1);
      ra = AW'($urandom);
      rl = LW'($urandom);
      to = ($urandom_range(0, 5) == 0);
      run_cmd(p, rrw, ra, rl, int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1), int'($urandom_range(0, TO - 1)),
              ($urandom_range(0, 1) == 1), to, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
